// File: rtl/rs232_cmd_ctrl.sv
// ============================================================================
//  Module   : rs232_cmd_ctrl
//  Purpose  : Frames the RS232 receiver byte stream (STX, LEN, payload, CHK)
//             into validated commands with inter-byte timeout and handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rs232_cmd_ctrl #(
   parameter int unsigned TIMEOUT_CNT = 225000,
   parameter logic [7:0]  STX         = 8'h02,
   parameter int unsigned MAX_LEN     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rs232_en,
   input  logic [7:0]             rx_data,
   output logic                   cmd_valid,
   input  logic                   cmd_ack,
   output logic [3:0]             cmd_len,
   output logic [8*MAX_LEN-1:0]   cmd_data,
   output logic                   err,
   output logic [2:0]             err_code,
   output logic                   busy
);

   localparam int unsigned c_idx_w    = $clog2(MAX_LEN);
   localparam logic [19:0] c_tmo_last = 20'(TIMEOUT_CNT - 1);
   localparam logic [7:0]  c_max_len  = 8'(MAX_LEN);

   localparam logic [2:0] c_err_chk  = 3'd1;
   localparam logic [2:0] c_err_len  = 3'd2;
   localparam logic [2:0] c_err_tmo  = 3'd3;
   localparam logic [2:0] c_err_ovr  = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LEN  = 2'd1,
      S_DATA = 2'd2,
      S_CHK  = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   r_en_d;
   logic [19:0]            r_tmo_cnt;
   logic [3:0]             r_len;
   logic [7:0]             r_chk;
   logic [c_idx_w-1:0]     r_idx;
   logic [8*MAX_LEN-1:0]   r_buf;

   logic                   w_byte_stb;
   logic                   w_len_ok;
   logic                   w_last_data;
   logic                   w_tmo;
   logic                   w_good;
   logic                   w_load;
   logic                   w_err;
   logic [2:0]             w_err_code;

   assign w_byte_stb  = rs232_en & ~r_en_d;
   assign w_len_ok    = (rx_data != 8'd0) && (rx_data <= c_max_len);
   assign w_last_data = (4'(r_idx) == (r_len - 4'd1));
   // A byte on the expiry edge wins over the timeout.
   assign w_tmo       = (r_state != S_IDLE) && !w_byte_stb && (r_tmo_cnt == c_tmo_last);
   assign w_load      = w_good && (!cmd_valid || cmd_ack);
   assign busy        = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_good     = 1'b0;
      w_err      = 1'b0;
      w_err_code = 3'd0;
      case (r_state)
         S_IDLE: begin
            if (w_byte_stb && (rx_data == STX)) begin
               w_next = S_LEN;
            end
         end
         S_LEN: begin
            if (w_byte_stb) begin
               if (w_len_ok) begin
                  w_next = S_DATA;
               end else begin
                  w_next     = S_IDLE;
                  w_err      = 1'b1;
                  w_err_code = c_err_len;
               end
            end
         end
         S_DATA: begin
            if (w_byte_stb && w_last_data) begin
               w_next = S_CHK;
            end
         end
         S_CHK: begin
            if (w_byte_stb) begin
               w_next = S_IDLE;
               if (rx_data == r_chk) begin
                  w_good = 1'b1;
                  if (cmd_valid && !cmd_ack) begin
                     w_err      = 1'b1;
                     w_err_code = c_err_ovr;
                  end
               end else begin
                  w_err      = 1'b1;
                  w_err_code = c_err_chk;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
      if (w_tmo) begin
         w_next     = S_IDLE;
         w_err      = 1'b1;
         w_err_code = c_err_tmo;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en_d    <= 1'b0;
         r_tmo_cnt <= '0;
         r_len     <= '0;
         r_chk     <= '0;
         r_idx     <= '0;
         r_buf     <= '0;
         cmd_valid <= 1'b0;
         cmd_len   <= '0;
         cmd_data  <= '0;
         err       <= 1'b0;
         err_code  <= '0;
      end else begin
         r_en_d <= rs232_en;

         if ((r_state == S_IDLE) || w_byte_stb) begin
            r_tmo_cnt <= '0;
         end else begin
            r_tmo_cnt <= r_tmo_cnt + 20'd1;
         end

         // Clearing on entry to LEN keeps unused payload bytes at zero.
         if ((r_state == S_IDLE) && (w_next == S_LEN)) begin
            r_buf <= '0;
         end

         if ((r_state == S_LEN) && w_byte_stb) begin
            r_len <= rx_data[3:0];
            r_chk <= rx_data;
            r_idx <= '0;
         end

         if ((r_state == S_DATA) && w_byte_stb) begin
            r_buf[{r_idx, 3'b000} +: 8] <= rx_data;
            r_chk                      <= r_chk ^ rx_data;
            r_idx                      <= r_idx + 1'b1;
         end

         if (w_load) begin
            cmd_valid <= 1'b1;
            cmd_len   <= r_len;
            cmd_data  <= r_buf;
         end else if (cmd_ack) begin
            cmd_valid <= 1'b0;
         end

         err <= w_err;
         if (w_err) begin
            err_code <= w_err_code;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rs232_cmd_ctrl.sv
// ============================================================================
//  Module   : tb_rs232_cmd_ctrl
//  Purpose  : Randomised self-checking bench for rs232_cmd_ctrl against a
//             frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rs232_cmd_ctrl;

   localparam int unsigned TMO   = 50;
   localparam logic [7:0]  STX_B = 8'h02;

   logic        clk;
   logic        reset;
   logic        rs232_en;
   logic [7:0]  rx_data;
   logic        cmd_valid;
   logic        cmd_ack;
   logic [3:0]  cmd_len;
   logic [63:0] cmd_data;
   logic        err;
   logic [2:0]  err_code;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Reference model: the command the consumer should currently see.
   logic        m_valid;
   logic [3:0]  m_len;
   logic [63:0] m_data;

   logic [7:0]  frm[$];
   logic [2:0]  err_q[$];

   rs232_cmd_ctrl #(
      .TIMEOUT_CNT (TMO),
      .STX         (STX_B),
      .MAX_LEN     (8)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .rs232_en  (rs232_en),
      .rx_data   (rx_data),
      .cmd_valid (cmd_valid),
      .cmd_ack   (cmd_ack),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
      .err       (err),
      .err_code  (err_code),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      if (err) err_q.push_back(err_code);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic put_byte(input logic [7:0] b, input logic ack);
      @(negedge clk);
      rs232_en = 1'b0;
      cmd_ack  = 1'b0;
      @(negedge clk);
      rs232_en = 1'b1;
      rx_data  = b;
      cmd_ack  = ack;
      @(posedge clk);
      #1;
      cmd_ack = 1'b0;
   endtask

   task automatic check_cmd(input string tag);
      checks++;
      if (cmd_valid !== m_valid) begin
         errors++;
         $display("FAIL %s cmd_valid: got %b want %b", tag, cmd_valid, m_valid);
      end
      if (m_valid) begin
         checks++;
         if (cmd_len !== m_len || cmd_data !== m_data) begin
            errors++;
            $display("FAIL %s cmd: got len %0d data %h want len %0d data %h",
                     tag, cmd_len, cmd_data, m_len, m_data);
         end
      end
   endtask

   task automatic do_ack();
      @(negedge clk);
      cmd_ack = 1'b1;
      @(posedge clk);
      #1;
      cmd_ack = 1'b0;
      m_valid = 1'b0;
      check_cmd("ack");
   endtask

   // Builds a random frame: kind 0 good, 1 bad checksum, 2 bad length.
   task automatic build_frame(input int kind);
      int          len;
      logic [7:0]  x;
      logic [7:0]  b;
      frm.delete();
      frm.push_back(STX_B);
      if (kind == 2) begin
         if ($urandom_range(0, 1) == 0) x = 8'h00;
         else x = 8'($urandom_range(9, 255));
         frm.push_back(x);
      end else begin
         len = $urandom_range(1, 8);
         x   = 8'(len);
         frm.push_back(x);
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            frm.push_back(b);
            x ^= b;
         end
         if (kind == 1) x ^= 8'($urandom_range(1, 255));
         frm.push_back(x);
      end
   endtask

   // Sends optional junk then frm, and checks the outcome the frame rules predict.
   task automatic run_frame(input int ngarb, input logic ack_last, input string tag);
      int          len;
      int          nerr;
      logic [7:0]  x;
      logic [7:0]  g;
      logic [2:0]  code;
      logic [63:0] pay;
      len  = int'(frm[1]);
      pay  = '0;
      code = 3'd0;
      if (len == 0 || len > 8) begin
         code = 3'd2;
      end else begin
         x = frm[1];
         for (int i = 0; i < len; i++) begin
            x ^= frm[2+i];
            pay[8*i +: 8] = frm[2+i];
         end
         if (x != frm[len+2]) code = 3'd1;
         else if (m_valid && !ack_last) code = 3'd4;
      end

      nerr = err_q.size();
      for (int i = 0; i < ngarb; i++) begin
         g = 8'($urandom);
         if (g == STX_B) g = 8'h41;
         put_byte(g, 1'b0);
      end
      for (int i = 0; i < frm.size(); i++) begin
         put_byte(frm[i], ack_last && (i == frm.size() - 1));
      end

      if (code == 3'd0) begin
         m_valid = 1'b1;
         m_len   = 4'(len);
         m_data  = pay;
      end else if (ack_last && m_valid) begin
         m_valid = 1'b0;
      end

      check_cmd(tag);
      checks++;
      if (err !== (code != 3'd0)) begin
         errors++;
         $display("FAIL %s err strobe: got %b want %b", tag, err, code != 3'd0);
      end
      if (code != 3'd0) begin
         checks++;
         if (err_code !== code) begin
            errors++;
            $display("FAIL %s err_code: got %0d want %0d", tag, err_code, code);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy after frame: got %b want 0", tag, busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL %s err width: got %b want 0 one clock later", tag, err);
      end
      @(negedge clk);
      checks++;
      if (err_q.size() - nerr != ((code != 3'd0) ? 1 : 0)) begin
         errors++;
         $display("FAIL %s err count: got %0d want %0d", tag, err_q.size() - nerr,
                  (code != 3'd0) ? 1 : 0);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      rs232_en = 1'b0;
      rx_data  = 8'h00;
      cmd_ack  = 1'b0;
      m_valid  = 1'b0;
      m_len    = '0;
      m_data   = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_valid, cmd_len, cmd_data, err, err_code, busy} !== '0) begin
         errors++;
         $display("FAIL reset: got valid %b len %0d data %h err %b code %0d busy %b want all 0",
                  cmd_valid, cmd_len, cmd_data, err, err_code, busy);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_good_frame();
      frm = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      run_frame(0, 1'b0, "good_fixed");
      checks++;
      if (cmd_data !== 64'h0000_0000_0033_2211 || cmd_len !== 4'd3) begin
         errors++;
         $display("FAIL good_fixed literal: got len %0d data %h want 3 0000000000332211",
                  cmd_len, cmd_data);
      end
      do_ack();
   endtask

   task automatic test_bad_checksum();
      frm = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h55};
      run_frame(0, 1'b0, "bad_chk");
   endtask

   task automatic test_bad_length();
      int nerr;
      nerr = err_q.size();
      put_byte(8'h41, 1'b0);
      put_byte(8'h0D, 1'b0);
      @(negedge clk);
      checks++;
      if (err_q.size() != nerr || busy !== 1'b0) begin
         errors++;
         $display("FAIL junk: got %0d errs busy %b want 0 errs busy 0", err_q.size() - nerr, busy);
      end
      frm = '{8'h02, 8'h00};
      run_frame(0, 1'b0, "len0");
      frm = '{8'h02, 8'h09};
      run_frame(0, 1'b0, "len9");
   endtask

   task automatic test_timeout();
      int k;
      logic got;
      put_byte(STX_B, 1'b0);
      put_byte(8'h02, 1'b0);
      put_byte(8'hAA, 1'b0);
      k   = 0;
      got = 1'b0;
      while (k < TMO + 10 && !got) begin
         @(posedge clk);
         #1;
         k++;
         if (err) got = 1'b1;
      end
      checks++;
      if (!got || k != TMO || err_code !== 3'd3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout: got seen %b after %0d clocks code %0d busy %b want 1 after %0d code 3 busy 0",
                  got, k, err_code, busy, TMO);
      end
      check_cmd("timeout");

      // Same silence, but a byte lands on the expiry edge.
      put_byte(STX_B, 1'b0);
      put_byte(8'h02, 1'b0);
      put_byte(8'hAA, 1'b0);
      @(negedge clk);
      rs232_en = 1'b0;
      repeat (TMO - 2) @(negedge clk);
      @(negedge clk);
      rs232_en = 1'b1;
      rx_data  = 8'hBB;
      @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_edge: got err %b busy %b want err 0 busy 1", err, busy);
      end
      put_byte(8'h13, 1'b0);
      m_valid = 1'b1;
      m_len   = 4'd2;
      m_data  = 64'h0000_0000_0000_BBAA;
      check_cmd("timeout_edge_frame");
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_edge_frame err: got %b want 0", err);
      end
      do_ack();
   endtask

   task automatic test_overrun();
      build_frame(0);
      run_frame(0, 1'b0, "ovr_first");
      build_frame(0);
      run_frame(0, 1'b0, "ovr_second");
   endtask

   task automatic test_back_to_back();
      build_frame(0);
      run_frame(0, 1'b1, "b2b_ack");
      build_frame(0);
      run_frame(1, 1'b1, "b2b_ack2");
      do_ack();
   endtask

   task automatic test_random();
      int kind;
      for (int n = 0; n < 24; n++) begin
         kind = $urandom_range(0, 3);
         build_frame((kind < 2) ? 0 : kind - 1);
         run_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
         if ($urandom_range(0, 1) == 1) do_ack();
      end
   endtask

   task automatic test_reset_mid_frame();
      build_frame(0);
      run_frame(0, 1'b0, "pre_reset");
      put_byte(STX_B, 1'b0);
      put_byte(8'h05, 1'b0);
      put_byte(8'h5A, 1'b0);
      put_byte(8'hC3, 1'b0);
      @(negedge clk);
      rs232_en = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      m_valid = 1'b0;
      checks++;
      if ({cmd_valid, cmd_len, cmd_data, err, err_code, busy} !== '0) begin
         errors++;
         $display("FAIL mid_reset: got valid %b len %0d data %h err %b code %0d busy %b want all 0",
                  cmd_valid, cmd_len, cmd_data, err, err_code, busy);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      build_frame(0);
      run_frame(0, 1'b0, "post_reset");
      do_ack();
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_bad_length();
      test_timeout();
      test_overrun();
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
